// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds issued ops until both operands are known, dispatches lowest-index ready entry.
// Issue-to-dispatch latency one edge, wakeup-to-dispatch one edge; en=0 freezes everything, full_o stalls the decoder.
`ifndef OP_W
`define OP_W 6
`endif
`ifndef ROB_BIT
`define ROB_BIT 4
`endif
`ifndef DAT_W
`define DAT_W 32
`endif

module alu_reservation_station #(
  parameter int RS_N   = 8,
  parameter int RS_BIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear_i,
  input  logic                iss_en_i,
  input  logic [`OP_W-1:0]    iss_op_i,
  input  logic                iss_ic_i,
  input  logic [`ROB_BIT-1:0] iss_qd_i,
  input  logic                iss_rdy_s_i,
  input  logic                iss_rdy_t_i,
  input  logic [`ROB_BIT-1:0] iss_qs_i,
  input  logic [`ROB_BIT-1:0] iss_qt_i,
  input  logic [`DAT_W-1:0]   iss_vs_i,
  input  logic [`DAT_W-1:0]   iss_vt_i,
  input  logic [`DAT_W-1:0]   iss_imm_i,
  input  logic [`DAT_W-1:0]   iss_pc_i,
  output logic                full_o,
  input  logic                cdb_alu_en_i,
  input  logic                cdb_lsb_en_i,
  input  logic [`ROB_BIT-1:0] cdb_alu_q_i,
  input  logic [`ROB_BIT-1:0] cdb_lsb_q_i,
  input  logic [`DAT_W-1:0]   cdb_alu_v_i,
  input  logic [`DAT_W-1:0]   cdb_lsb_v_i,
  output logic                alu_en_o,
  output logic [`OP_W-1:0]    alu_op_o,
  output logic                alu_ic_o,
  output logic [`ROB_BIT-1:0] alu_qd_o,
  output logic [`DAT_W-1:0]   alu_vs_o,
  output logic [`DAT_W-1:0]   alu_vt_o,
  output logic [`DAT_W-1:0]   alu_imm_o,
  output logic [`DAT_W-1:0]   alu_pc_o
);

  typedef struct packed {
    logic                valid;
    logic [`OP_W-1:0]    op;
    logic                ic;
    logic [`ROB_BIT-1:0] qd;
    logic                rdy_s;
    logic [`ROB_BIT-1:0] qs;
    logic [`DAT_W-1:0]   vs;
    logic                rdy_t;
    logic [`ROB_BIT-1:0] qt;
    logic [`DAT_W-1:0]   vt;
    logic [`DAT_W-1:0]   imm;
    logic [`DAT_W-1:0]   pc;
  } entry_t;

  entry_t              ent [RS_N];
  entry_t              iss_ent;
  logic [RS_N-1:0]     vld_vec;
  logic [RS_N-1:0]     rdy_vec;
  logic                disp_vld;
  logic [RS_BIT-1:0]   disp_idx;
  logic [RS_BIT-1:0]   free_idx;

  // Returns {rdy, value}; the ALU bus is checked first so it wins a tag collision.
  function automatic logic [`DAT_W:0] wake(input logic rdy, input logic [`ROB_BIT-1:0] q,
                                           input logic [`DAT_W-1:0] v);
    if (rdy) return {1'b1, v};
    if (cdb_alu_en_i && cdb_alu_q_i == q) return {1'b1, cdb_alu_v_i};
    if (cdb_lsb_en_i && cdb_lsb_q_i == q) return {1'b1, cdb_lsb_v_i};
    return {1'b0, v};
  endfunction

  always_comb begin
    for (int i = 0; i < RS_N; i++) begin
      vld_vec[i] = ent[i].valid;
      rdy_vec[i] = ent[i].valid & ent[i].rdy_s & ent[i].rdy_t;
    end
  end

  always_comb begin
    disp_vld = |rdy_vec;
    disp_idx = '0;
    free_idx = '0;
    for (int i = RS_N - 1; i >= 0; i--) begin
      if (rdy_vec[i])  disp_idx = RS_BIT'(i);
      if (!vld_vec[i]) free_idx = RS_BIT'(i);
    end
  end

  assign full_o = &vld_vec;

  always_comb begin
    iss_ent       = '0;
    iss_ent.valid = 1'b1;
    iss_ent.op    = iss_op_i;
    iss_ent.ic    = iss_ic_i;
    iss_ent.qd    = iss_qd_i;
    iss_ent.qs    = iss_qs_i;
    iss_ent.qt    = iss_qt_i;
    iss_ent.imm   = iss_imm_i;
    iss_ent.pc    = iss_pc_i;
    {iss_ent.rdy_s, iss_ent.vs} = wake(iss_rdy_s_i, iss_qs_i, iss_vs_i);
    {iss_ent.rdy_t, iss_ent.vt} = wake(iss_rdy_t_i, iss_qt_i, iss_vt_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_N; i++) ent[i] <= '0;
      alu_en_o  <= 1'b0;
      alu_op_o  <= '0;
      alu_ic_o  <= 1'b0;
      alu_qd_o  <= '0;
      alu_vs_o  <= '0;
      alu_vt_o  <= '0;
      alu_imm_o <= '0;
      alu_pc_o  <= '0;
    end else if (en) begin
      if (clear_i) begin
        for (int i = 0; i < RS_N; i++) ent[i].valid <= 1'b0;
        alu_en_o <= 1'b0;
      end else begin
        for (int i = 0; i < RS_N; i++) begin
          if (ent[i].valid) begin
            {ent[i].rdy_s, ent[i].vs} <= wake(ent[i].rdy_s, ent[i].qs, ent[i].vs);
            {ent[i].rdy_t, ent[i].vt} <= wake(ent[i].rdy_t, ent[i].qt, ent[i].vt);
          end
        end
        alu_en_o <= disp_vld;
        if (disp_vld) begin
          ent[disp_idx].valid <= 1'b0;
          alu_op_o  <= ent[disp_idx].op;
          alu_ic_o  <= ent[disp_idx].ic;
          alu_qd_o  <= ent[disp_idx].qd;
          alu_vs_o  <= ent[disp_idx].vs;
          alu_vt_o  <= ent[disp_idx].vt;
          alu_imm_o <= ent[disp_idx].imm;
          alu_pc_o  <= ent[disp_idx].pc;
        end
        // free_idx always points at a slot that was empty before this edge, never the dispatched one
        if (iss_en_i && !full_o) ent[free_idx] <= iss_ent;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomised plus directed bench for alu_reservation_station with a slot-array reference model and scoreboard.
`ifndef OP_W
`define OP_W 6
`endif
`ifndef ROB_BIT
`define ROB_BIT 4
`endif
`ifndef DAT_W
`define DAT_W 32
`endif

module tb_alu_reservation_station;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst, en, clear_i, iss_en_i, iss_ic_i, iss_rdy_s_i, iss_rdy_t_i;
  logic [`OP_W-1:0] iss_op_i;
  logic [`ROB_BIT-1:0] iss_qd_i, iss_qs_i, iss_qt_i, cdb_alu_q_i, cdb_lsb_q_i;
  logic [`DAT_W-1:0] iss_vs_i, iss_vt_i, iss_imm_i, iss_pc_i, cdb_alu_v_i, cdb_lsb_v_i;
  logic cdb_alu_en_i, cdb_lsb_en_i, full_o, alu_en_o, alu_ic_o;
  logic [`OP_W-1:0] alu_op_o;
  logic [`ROB_BIT-1:0] alu_qd_o;
  logic [`DAT_W-1:0] alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o;

  alu_reservation_station #(.RS_N(8), .RS_BIT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .clear_i(clear_i), .iss_en_i(iss_en_i),
    .iss_op_i(iss_op_i), .iss_ic_i(iss_ic_i), .iss_qd_i(iss_qd_i),
    .iss_rdy_s_i(iss_rdy_s_i), .iss_rdy_t_i(iss_rdy_t_i), .iss_qs_i(iss_qs_i), .iss_qt_i(iss_qt_i),
    .iss_vs_i(iss_vs_i), .iss_vt_i(iss_vt_i), .iss_imm_i(iss_imm_i), .iss_pc_i(iss_pc_i),
    .full_o(full_o), .cdb_alu_en_i(cdb_alu_en_i), .cdb_lsb_en_i(cdb_lsb_en_i),
    .cdb_alu_q_i(cdb_alu_q_i), .cdb_lsb_q_i(cdb_lsb_q_i), .cdb_alu_v_i(cdb_alu_v_i),
    .cdb_lsb_v_i(cdb_lsb_v_i), .alu_en_o(alu_en_o), .alu_op_o(alu_op_o), .alu_ic_o(alu_ic_o),
    .alu_qd_o(alu_qd_o), .alu_vs_o(alu_vs_o), .alu_vt_o(alu_vt_o), .alu_imm_o(alu_imm_o),
    .alu_pc_o(alu_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic en; logic full;
    logic [`OP_W-1:0] op; logic ic; logic [`ROB_BIT-1:0] qd;
    logic [`DAT_W-1:0] vs, vt, imm, pc;
  } rec_t;

  rec_t exp_q[$];
  int vectors = 0, miscompares = 0;

  // Model: each slot either empty or holding an instruction; an operand waits on tag w (>=0) or is known (w=-1).
  bit m_busy[N];
  int m_ws[N], m_wt[N];
  logic [`DAT_W-1:0] m_vs[N], m_vt[N], m_imm[N], m_pc[N];
  logic [`OP_W-1:0] m_op[N];
  logic m_ic[N];
  logic [`ROB_BIT-1:0] m_qd[N];
  rec_t m_out;

  function automatic void snoop(inout int w, inout logic [`DAT_W-1:0] v);
    if (w < 0) return;
    if (cdb_alu_en_i && int'(cdb_alu_q_i) == w) begin w = -1; v = cdb_alu_v_i; end
    else if (cdb_lsb_en_i && int'(cdb_lsb_q_i) == w) begin w = -1; v = cdb_lsb_v_i; end
  endfunction

  function automatic int occupancy();
    int c = 0;
    foreach (m_busy[i]) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic model_edge();
    int pick = -1, slot = -1, w;
    logic [`DAT_W-1:0] v;
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_out = '0;
    end else if (en) begin
      if (clear_i) begin
        foreach (m_busy[i]) m_busy[i] = 0;
        m_out.en = 0;
      end else begin
        for (int i = N - 1; i >= 0; i--) begin
          if (m_busy[i] && m_ws[i] < 0 && m_wt[i] < 0) pick = i;
          if (!m_busy[i]) slot = i;
        end
        m_out.en = (pick >= 0);
        if (pick >= 0) begin
          m_out.op = m_op[pick]; m_out.ic = m_ic[pick]; m_out.qd = m_qd[pick];
          m_out.vs = m_vs[pick]; m_out.vt = m_vt[pick];
          m_out.imm = m_imm[pick]; m_out.pc = m_pc[pick];
          m_busy[pick] = 0;
        end
        for (int i = 0; i < N; i++) if (m_busy[i]) begin
          w = m_ws[i]; v = m_vs[i]; snoop(w, v); m_ws[i] = w; m_vs[i] = v;
          w = m_wt[i]; v = m_vt[i]; snoop(w, v); m_wt[i] = w; m_vt[i] = v;
        end
        if (iss_en_i && slot >= 0) begin
          m_busy[slot] = 1; m_op[slot] = iss_op_i; m_ic[slot] = iss_ic_i; m_qd[slot] = iss_qd_i;
          m_imm[slot] = iss_imm_i; m_pc[slot] = iss_pc_i;
          w = iss_rdy_s_i ? -1 : int'(iss_qs_i); v = iss_vs_i; snoop(w, v); m_ws[slot] = w; m_vs[slot] = v;
          w = iss_rdy_t_i ? -1 : int'(iss_qt_i); v = iss_vt_i; snoop(w, v); m_wt[slot] = w; m_vt[slot] = v;
        end
      end
    end
    m_out.full = (occupancy() == N);
    exp_q.push_back(m_out);
  endtask

  task automatic idle();
    rst = 0; en = 1; clear_i = 0; iss_en_i = 0; iss_op_i = '0; iss_ic_i = 0; iss_qd_i = '0;
    iss_rdy_s_i = 1; iss_rdy_t_i = 1; iss_qs_i = '0; iss_qt_i = '0; iss_vs_i = '0; iss_vt_i = '0;
    iss_imm_i = '0; iss_pc_i = '0; cdb_alu_en_i = 0; cdb_lsb_en_i = 0; cdb_alu_q_i = '0;
    cdb_lsb_q_i = '0; cdb_alu_v_i = '0; cdb_lsb_v_i = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin idle(); tick(); end
  endtask

  task automatic issue(input logic [`ROB_BIT-1:0] qd, input logic rs, input logic [`ROB_BIT-1:0] qs,
                       input logic [`DAT_W-1:0] vs, input logic rt, input logic [`ROB_BIT-1:0] qt,
                       input logic [`DAT_W-1:0] vt);
    iss_en_i = 1; iss_op_i = `OP_W'(qd + 1); iss_ic_i = qd[0]; iss_qd_i = qd;
    iss_rdy_s_i = rs; iss_qs_i = qs; iss_vs_i = vs;
    iss_rdy_t_i = rt; iss_qt_i = qt; iss_vt_i = vt;
    iss_imm_i = 32'h100 + 32'(qd); iss_pc_i = 32'h8000 + 32'(qd) * 4;
  endtask

  // Monitor: one expected record per clock edge, checked half a cycle later.
  initial begin
    rec_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{alu_en_o, full_o, alu_op_o, alu_ic_o, alu_qd_o, alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o};
        vectors++;
        if ({a.en, a.full} !== {e.en, e.full}) begin
          miscompares++;
          $display("FAIL en_full t=%0t got en=%b full=%b want en=%b full=%b", $time, a.en, a.full, e.en, e.full);
        end
        vectors++;
        if (a[$bits(rec_t)-3:0] !== e[$bits(rec_t)-3:0]) begin
          miscompares++;
          $display("FAIL payload t=%0t got op=%h ic=%b qd=%h vs=%h vt=%h imm=%h pc=%h want op=%h ic=%b qd=%h vs=%h vt=%h imm=%h pc=%h",
                   $time, a.op, a.ic, a.qd, a.vs, a.vt, a.imm, a.pc, e.op, e.ic, e.qd, e.vs, e.vt, e.imm, e.pc);
        end
      end
    end
  end

  initial begin
    m_out = '0;
    foreach (m_busy[i]) m_busy[i] = 0;
    idle(); rst = 1;
    tick(); tick();
    idle_ticks(1);

    // both operands ready
    idle(); issue(4'd3, 1, 4'd0, 32'd5, 1, 4'd0, 32'd7); tick();
    idle_ticks(3);

    // s operand woken by the LSB bus one cycle later
    idle(); issue(4'd4, 0, 4'd2, 32'd0, 1, 4'd0, 32'd1); tick();
    idle(); cdb_lsb_en_i = 1; cdb_lsb_q_i = 4'd2; cdb_lsb_v_i = 32'h10; tick();
    idle_ticks(3);

    // forwarding in the issue cycle
    idle(); issue(4'd5, 1, 4'd0, 32'd2, 0, 4'd6, 32'd0);
    cdb_alu_en_i = 1; cdb_alu_q_i = 4'd6; cdb_alu_v_i = 32'd9; tick();
    idle_ticks(3);

    // fill, overflow issue, then mass wakeup
    for (int i = 0; i < 9; i++) begin
      idle(); issue(4'(i + 7), 0, 4'd1, 32'd0, 1, 4'd0, 32'(i)); tick();
    end
    idle(); cdb_alu_en_i = 1; cdb_alu_q_i = 4'd1; cdb_alu_v_i = 32'hAB; tick();
    idle_ticks(10);

    // flush with simultaneous issue and broadcast
    for (int i = 0; i < 3; i++) begin
      idle(); issue(4'(i), 0, 4'd5, 32'd0, 1, 4'd0, 32'd3); tick();
    end
    idle(); clear_i = 1; issue(4'd9, 1, 4'd0, 32'd1, 1, 4'd0, 32'd2);
    cdb_alu_en_i = 1; cdb_alu_q_i = 4'd5; cdb_alu_v_i = 32'd44; tick();
    idle(); cdb_alu_en_i = 1; cdb_alu_q_i = 4'd5; cdb_alu_v_i = 32'd44; tick();
    idle_ticks(3);

    // stall with a ready entry pending
    idle(); issue(4'd2, 1, 4'd0, 32'd11, 1, 4'd0, 32'd12); tick();
    idle(); issue(4'd6, 1, 4'd0, 32'd13, 1, 4'd0, 32'd14); tick();
    for (int i = 0; i < 3; i++) begin idle(); en = 0; tick(); end
    idle_ticks(3);

    // randomised traffic, including tag collisions, stalls, flushes and resets
    for (int c = 0; c < 3000; c++) begin
      idle();
      en = ($urandom_range(0, 9) != 0);
      clear_i = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) != 0)
        issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)),
              $urandom, 1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)), $urandom);
      iss_op_i = `OP_W'($urandom);
      iss_pc_i = $urandom;
      cdb_alu_en_i = ($urandom_range(0, 1) == 0);
      cdb_alu_q_i = 4'($urandom_range(0, 5)); cdb_alu_v_i = $urandom;
      cdb_lsb_en_i = ($urandom_range(0, 1) == 0);
      cdb_lsb_q_i = 4'($urandom_range(0, 5)); cdb_lsb_v_i = $urandom;
      tick();
    end
    idle_ticks(12);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending records want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
